sn54170_fifo_ctrl: RTL and testbench
====================================

SN54170_FIFO_CTRL -- requirements
Module: sn54170_fifo_ctrl

Interface
REQ-001 Parameters: none; data width is fixed at 4 bits and register-file depth at 4 words, matching sn54170.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  reset, synchronous and active-low.
REQ-004 s_data  input  4  upstream write word.
REQ-005 s_valid  input  1  upstream word present.
REQ-006 s_ready  output  1  controller can accept a word this cycle.
REQ-007 m_data  output  4  downstream read word, registered.
REQ-008 m_valid  output  1  m_data holds a valid word.
REQ-009 m_ready  input  1  downstream accepts m_data this cycle.
REQ-010 rf_data_in  output  4  word to sn54170 data_in.
REQ-011 rf_wr_enb  output  1  sn54170 write enable, active-high, one cycle per write.
REQ-012 rf_wr_sel  output  2  sn54170 write address.
REQ-013 rf_rd_enb  output  1  sn54170 read enable, active-high.
REQ-014 rf_rd_sel  output  2  sn54170 read address.
REQ-015 rf_data_out  input  4  sn54170 data_out; combinational read of rf_rd_sel.
REQ-016 count  output  3  words held in register file, 0..4; excludes the m_data stage.
REQ-017 full  output  1  count==4.
REQ-018 empty  output  1  count==0.

Function
REQ-019 State SHALL be wr_ptr[1:0], rd_ptr[1:0], count[2:0], m_data[3:0] and m_valid; no other storage.
REQ-020 s_ready SHALL equal (count!=4) && reset_n; it is combinational from registered state and does not depend on m_ready.
REQ-021 push SHALL equal s_valid && s_ready; rf_wr_enb=push, rf_wr_sel=wr_ptr, rf_data_in=s_data in the same cycle.
REQ-022 On push, wr_ptr SHALL increment modulo 4 (3 -> 0).
REQ-023 rf_rd_enb SHALL equal !empty; rf_rd_sel SHALL equal rd_ptr at all times.
REQ-024 load SHALL equal (count!=0) && (!m_valid || m_ready); count is the value before the edge, so a word written this cycle cannot be loaded until the next cycle.
REQ-025 On load: m_data<=rf_data_out, m_valid<=1, and rd_ptr increments modulo 4.
REQ-026 If m_valid && m_ready && !load, then m_valid<=0 and m_data holds its value.
REQ-027 While m_valid && !m_ready, m_data and m_valid SHALL stay stable.
REQ-028 count next = count + push - load; push and load together leave count unchanged.
REQ-029 Capacity SHALL be 5 words: 4 in the file plus 1 in m_data.
REQ-030 Latency: with the controller empty, a word pushed at edge k SHALL appear with m_valid=1 after edge k+1.
REQ-031 With m_ready held at 1 and s_valid held at 1, throughput SHALL be 1 word per cycle after the first.
REQ-032 Ordering SHALL be strict FIFO; no word is dropped or duplicated.
REQ-033 When full, s_ready=0 even if a load occurs in that cycle; s_ready rises the cycle after count drops.

Reset
REQ-034 When reset_n=0 at a rising edge: wr_ptr=0, rd_ptr=0, count=0, m_valid=0, m_data=4'h0.
REQ-035 While reset_n=0: s_ready=0 and rf_wr_enb=0; rf_rd_enb=0 follows from empty.
REQ-036 Reset mid-operation SHALL discard all held words; register-file contents are not cleared but are never read back.

Verification
REQ-037 Fill: after reset, push 1,2,3,4,5 with m_ready=0 -> rf_wr_sel 0,1,2,3,0; then m_data=1, m_valid=1, count=4, full=1, s_ready=0.
REQ-038 Drain: from REQ-037 state set m_ready=1, s_valid=0 -> m_data 1,2,3,4,5 on consecutive cycles; then m_valid=0, empty=1.
REQ-039 Wrap/stream: push 0..9 back-to-back with m_ready=1 -> outputs 0..9 in order, one per cycle after first, rf_wr_sel/rf_rd_sel wrap 3->0.
REQ-040 Latency: empty controller, push 4'hA at edge k -> m_valid=1, m_data=4'hA after edge k+1, count returns to 0.
REQ-041 Backpressure: toggle m_ready randomly during 20-word stream -> m_data stable whenever m_valid && !m_ready; order preserved.
REQ-042 Reset mid-stream: count=3, m_valid=1, assert reset_n=0 one cycle -> all state zero next cycle; no old word emitted afterward.

Source files
------------

// File: rtl/sn54170_fifo_ctrl.sv
// FIFO controller wrapping an external sn54170 4x4 register file.
// Four words live in the file; a fifth sits in the registered m_data stage.
module sn54170_fifo_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [3:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [3:0] rf_data_in,
  output logic       rf_wr_enb,
  output logic [1:0] rf_wr_sel,
  output logic       rf_rd_enb,
  output logic [1:0] rf_rd_sel,
  input  logic [3:0] rf_data_out,
  output logic [2:0] count,
  output logic       full,
  output logic       empty
);

  localparam int unsigned DW    = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned CW    = 3;
  localparam int unsigned DEPTH = 4;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic          m_valid_q, m_valid_d;
  logic          push, load;

  // Handshake and register-file strobes, all decoded from registered state.
  always_comb begin
    full       = (count_q == CW'(DEPTH));
    empty      = (count_q == CW'(0));
    s_ready    = !full && reset_n;
    push       = s_valid && s_ready;
    load       = !empty && (!m_valid_q || m_ready);
    rf_wr_enb  = push;
    rf_wr_sel  = wr_ptr_q;
    rf_data_in = s_data;
    rf_rd_enb  = !empty;
    rf_rd_sel  = rd_ptr_q;
    count      = count_q;
    m_data     = m_data_q;
    m_valid    = m_valid_q;
  end

  // Next-state: a word written this cycle is only loadable from the next one.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    count_d   = count_q + CW'(push) - CW'(load);
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (load) begin
      m_data_d  = rf_data_out;
      m_valid_d = 1'b1;
      rd_ptr_d  = rd_ptr_q + AW'(1);
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
    end
  end

endmodule

// File: tb/tb_sn54170_fifo_ctrl.sv
// Self-checking bench for sn54170_fifo_ctrl with a behavioural 4x4 register file.
module tb_sn54170_fifo_ctrl;

  logic       clk;
  logic       reset_n;
  logic [3:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [3:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [3:0] rf_data_in;
  logic       rf_wr_enb;
  logic [1:0] rf_wr_sel;
  logic       rf_rd_enb;
  logic [1:0] rf_rd_sel;
  logic [3:0] rf_data_out;
  logic [2:0] count;
  logic       full;
  logic       empty;

  int n_checks = 0;
  int n_fail   = 0;

  sn54170_fifo_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .rf_data_in  (rf_data_in),
    .rf_wr_enb   (rf_wr_enb),
    .rf_wr_sel   (rf_wr_sel),
    .rf_rd_enb   (rf_rd_enb),
    .rf_rd_sel   (rf_rd_sel),
    .rf_data_out (rf_data_out),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  // sn54170 stand-in: synchronous write, combinational read.
  logic [3:0] rf_mem [4];
  always @(posedge clk) if (rf_wr_enb) rf_mem[rf_wr_sel] <= rf_data_in;
  assign rf_data_out = rf_mem[rf_rd_sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       rst_n;
    logic       sv;
    logic [3:0] sd;
    logic       mr;
    logic       pre_sr;
    logic       pre_wen;
    logic [1:0] pre_wsel;
    logic       post_mv;
    logic [3:0] post_md;
    logic [2:0] post_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic sv, logic [3:0] sd, logic mr, logic sr,
                              logic wen, logic [1:0] ws, logic mv, logic [3:0] md,
                              logic [2:0] c);
    vec_t v;
    v.rst_n = r; v.sv = sv; v.sd = sd; v.mr = mr;
    v.pre_sr = sr; v.pre_wen = wen; v.pre_wsel = ws;
    v.post_mv = mv; v.post_md = md; v.post_cnt = c;
    return v;
  endfunction

  task automatic drive(input logic r, input logic sv, input logic [3:0] sd, input logic mr);
    @(negedge clk);
    reset_n = r; s_valid = sv; s_data = sd; m_ready = mr;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 4'h0, 1'b0);
    @(posedge clk); #1;
  endtask

  // Stream 'nwords' words through with optional random backpressure.
  task automatic run_stream(input int nwords, input bit random_ready, input string tag);
    int   pushed, popped, cycles, last_pop_cyc;
    logic held_v;
    logic [3:0] held_d;
    logic mr;
    pushed = 0; popped = 0; cycles = 0; last_pop_cyc = -1;
    while (popped < nwords && cycles < 400) begin
      mr = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      drive(1'b1, pushed < nwords, 4'(pushed), mr);
      if (s_valid && s_ready) begin
        chk({tag, "_wr_sel"}, int'(rf_wr_sel), pushed % 4);
        pushed++;
      end
      if (m_valid && m_ready) begin
        chk({tag, "_order"}, int'(m_data), popped % 16);
        if (!random_ready && last_pop_cyc >= 0) chk({tag, "_gap"}, cycles - last_pop_cyc, 1);
        last_pop_cyc = cycles;
        popped++;
      end
      held_v = m_valid && !m_ready;
      held_d = m_data;
      @(posedge clk); #1;
      if (held_v) begin
        chk({tag, "_hold_valid"}, int'(m_valid), 1);
        chk({tag, "_hold_data"}, int'(m_data), int'(held_d));
      end
      cycles++;
    end
    chk({tag, "_all_out"}, popped, nwords);
    drive(1'b1, 1'b0, 4'h0, 1'b1);
    @(posedge clk); #1;
    chk({tag, "_empty_end"}, int'(empty), 1);
    chk({tag, "_mvalid_end"}, int'(m_valid), 0);
    chk({tag, "_rd_sel_end"}, int'(rf_rd_sel), nwords % 4);
  endtask

  initial begin
    reset_n = 1'b0; s_valid = 1'b0; s_data = 4'h0; m_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset, fill to 5 words, refused push, drain with full+load, then single-word latency.
    vecs.push_back(mk(0, 1, 4'hF, 0,  0, 0, 2'd0,  0, 4'h0, 3'd0));
    vecs.push_back(mk(1, 1, 4'h1, 0,  1, 1, 2'd0,  0, 4'h0, 3'd1));
    vecs.push_back(mk(1, 1, 4'h2, 0,  1, 1, 2'd1,  1, 4'h1, 3'd1));
    vecs.push_back(mk(1, 1, 4'h3, 0,  1, 1, 2'd2,  1, 4'h1, 3'd2));
    vecs.push_back(mk(1, 1, 4'h4, 0,  1, 1, 2'd3,  1, 4'h1, 3'd3));
    vecs.push_back(mk(1, 1, 4'h5, 0,  1, 1, 2'd0,  1, 4'h1, 3'd4));
    vecs.push_back(mk(1, 1, 4'h6, 0,  0, 0, 2'd1,  1, 4'h1, 3'd4));
    vecs.push_back(mk(1, 1, 4'h7, 1,  0, 0, 2'd1,  1, 4'h2, 3'd3));
    vecs.push_back(mk(1, 0, 4'h0, 1,  1, 0, 2'd1,  1, 4'h3, 3'd2));
    vecs.push_back(mk(1, 0, 4'h0, 1,  1, 0, 2'd1,  1, 4'h4, 3'd1));
    vecs.push_back(mk(1, 0, 4'h0, 1,  1, 0, 2'd1,  1, 4'h5, 3'd0));
    vecs.push_back(mk(1, 0, 4'h0, 1,  1, 0, 2'd1,  0, 4'h5, 3'd0));
    vecs.push_back(mk(1, 1, 4'hA, 1,  1, 1, 2'd1,  0, 4'h5, 3'd1));
    vecs.push_back(mk(1, 0, 4'h0, 1,  1, 0, 2'd2,  1, 4'hA, 3'd0));
    vecs.push_back(mk(1, 0, 4'h0, 1,  1, 0, 2'd2,  0, 4'hA, 3'd0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].sv, vecs[i].sd, vecs[i].mr);
      chk($sformatf("v%0d_s_ready", i), int'(s_ready), int'(vecs[i].pre_sr));
      chk($sformatf("v%0d_wr_enb", i), int'(rf_wr_enb), int'(vecs[i].pre_wen));
      chk($sformatf("v%0d_wr_sel", i), int'(rf_wr_sel), int'(vecs[i].pre_wsel));
      @(posedge clk); #1;
      chk($sformatf("v%0d_m_valid", i), int'(m_valid), int'(vecs[i].post_mv));
      chk($sformatf("v%0d_m_data", i), int'(m_data), int'(vecs[i].post_md));
      chk($sformatf("v%0d_count", i), int'(count), int'(vecs[i].post_cnt));
      chk($sformatf("v%0d_full", i), int'(full), int'(vecs[i].post_cnt == 3'd4));
      chk($sformatf("v%0d_empty", i), int'(empty), int'(vecs[i].post_cnt == 3'd0));
      chk($sformatf("v%0d_rd_enb", i), int'(rf_rd_enb), int'(vecs[i].post_cnt != 3'd0));
    end

    do_reset();
    run_stream(10, 1'b0, "stream");
    do_reset();
    run_stream(20, 1'b1, "bp");

    // Reset mid-stream: 3 words in the file, 1 in m_data.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 4'(4'hB + k), 1'b0);
      @(posedge clk); #1;
    end
    drive(1'b1, 1'b0, 4'h0, 1'b0);
    @(posedge clk); #1;
    chk("mid_count", int'(count), 3);
    chk("mid_m_valid", int'(m_valid), 1);
    chk("mid_m_data", int'(m_data), 4'hB);
    drive(1'b0, 1'b1, 4'h3, 1'b1);
    chk("mid_rst_s_ready", int'(s_ready), 0);
    chk("mid_rst_wr_enb", int'(rf_wr_enb), 0);
    @(posedge clk); #1;
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_m_valid", int'(m_valid), 0);
    chk("mid_rst_m_data", int'(m_data), 0);
    chk("mid_rst_wr_sel", int'(rf_wr_sel), 0);
    chk("mid_rst_rd_sel", int'(rf_rd_sel), 0);
    chk("mid_rst_rd_enb", int'(rf_rd_enb), 0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 4'h0, 1'b1);
      @(posedge clk); #1;
      chk("post_rst_no_word", int'(m_valid), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
